// File: rtl/deque_pkg.sv
// Shared types for the deque requester: opcode encoding, issuer FSM states
// and the default channel width.
`ifndef TOP_CHANWIDTH
`define TOP_CHANWIDTH 8
`endif

package deque_pkg;

  localparam int CHAN_WIDTH = `TOP_CHANWIDTH;

  typedef enum logic [1:0] {
    ENQ_BACK  = 2'd0,
    ENQ_FRONT = 2'd1,
    DEQ_FRONT = 2'd2,
    DEQ_BACK  = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // Dequeue opcodes are the upper half of the encoding.
  function automatic logic is_deq(op_t op);
    return op[1];
  endfunction

endpackage

// File: rtl/deque_op_issuer_if.sv
// Bundle of the command/response handshakes and the four deque req/cpl
// channels; master is the issuer's view, slave is the environment's view.
interface deque_op_issuer_if #(
  parameter int p_bitwidth = deque_pkg::CHAN_WIDTH,
  parameter int p_latwidth = 8
);
  import deque_pkg::*;

  // cmd and resp transfer on a cycle where val and rdy are both 1; val never
  // waits on rdy, and payload is held stable while val=1 and rdy=0.
  // A channel req stays 1 until the cycle its matching cpl is seen.
  logic                  cmd_val;
  logic                  cmd_rdy;
  op_t                   cmd_op;
  logic [p_bitwidth-1:0] cmd_data;

  logic                  resp_val;
  logic                  resp_rdy;
  op_t                   resp_op;
  logic [p_bitwidth-1:0] resp_data;
  logic [p_latwidth-1:0] resp_lat;
  logic                  timeout;

  logic                  enq_back_req;
  logic                  enq_front_req;
  logic                  deq_front_req;
  logic                  deq_back_req;
  logic                  enq_back_cpl;
  logic                  enq_front_cpl;
  logic                  deq_front_cpl;
  logic                  deq_back_cpl;
  logic [p_bitwidth-1:0] enq_back_data;
  logic [p_bitwidth-1:0] enq_front_data;
  logic [p_bitwidth-1:0] deq_front_data;
  logic [p_bitwidth-1:0] deq_back_data;

  modport master (
    input  cmd_val, cmd_op, cmd_data, resp_rdy,
    input  enq_back_cpl, enq_front_cpl, deq_front_cpl, deq_back_cpl,
    input  deq_front_data, deq_back_data,
    output cmd_rdy, resp_val, resp_op, resp_data, resp_lat, timeout,
    output enq_back_req, enq_front_req, deq_front_req, deq_back_req,
    output enq_back_data, enq_front_data
  );

  modport slave (
    output cmd_val, cmd_op, cmd_data, resp_rdy,
    output enq_back_cpl, enq_front_cpl, deq_front_cpl, deq_back_cpl,
    output deq_front_data, deq_back_data,
    input  cmd_rdy, resp_val, resp_op, resp_data, resp_lat, timeout,
    input  enq_back_req, enq_front_req, deq_front_req, deq_back_req,
    input  enq_back_data, enq_front_data
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that clears on clr, increments on inc and holds at all-ones.
module sat_counter #(
  parameter int p_width = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc,
  output logic [p_width-1:0] count
);

  localparam logic [p_width-1:0] ONE = {{(p_width-1){1'b0}}, 1'b1};

  logic [p_width-1:0] count_q;
  logic [p_width-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/deque_op_issuer.sv
// Issues one deque operation at a time: latches a command, holds the selected
// channel req until its cpl, then presents the result with its wait latency.
module deque_op_issuer
  import deque_pkg::*;
#(
  parameter int p_bitwidth = deque_pkg::CHAN_WIDTH,
  parameter int p_latwidth = 8,
  parameter int p_timeout  = 200
) (
  input  logic                clk,
  input  logic                rst,
  deque_op_issuer_if.master   io,
  output state_t              dbg_state_o
);

  localparam logic [p_latwidth-1:0] LAT_ONE     = {{(p_latwidth-1){1'b0}}, 1'b1};
  localparam logic [p_latwidth-1:0] LAT_MAX     = '1;
  localparam logic [p_latwidth-1:0] TIMEOUT_LAT = p_latwidth'(p_timeout);

  state_t                state_q;
  op_t                   op_q;
  logic [p_bitwidth-1:0] data_q;
  op_t                   resp_op_q;
  logic [p_bitwidth-1:0] resp_data_q;
  logic [p_latwidth-1:0] resp_lat_q;
  logic                  timeout_q;

  logic                  cnt_clr;
  logic                  cnt_inc;
  logic [p_latwidth-1:0] lat_count;
  logic [p_latwidth-1:0] lat_now;
  logic                  sel_cpl;
  logic [p_bitwidth-1:0] sel_deq_data;

  assign cnt_clr = (state_q == ST_IDLE) && io.cmd_val;
  assign cnt_inc = (state_q == ST_ISSUE);

  sat_counter #(.p_width(p_latwidth)) u_lat_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (lat_count)
  );

  // The counter holds completed ISSUE cycles; the current cycle counts too.
  assign lat_now = (lat_count == LAT_MAX) ? LAT_MAX : (lat_count + LAT_ONE);

  always_comb begin
    sel_cpl      = 1'b0;
    sel_deq_data = '0;
    case (op_q)
      ENQ_BACK:  sel_cpl = io.enq_back_cpl;
      ENQ_FRONT: sel_cpl = io.enq_front_cpl;
      DEQ_FRONT: begin
        sel_cpl      = io.deq_front_cpl;
        sel_deq_data = io.deq_front_data;
      end
      DEQ_BACK: begin
        sel_cpl      = io.deq_back_cpl;
        sel_deq_data = io.deq_back_data;
      end
      default: sel_cpl = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      op_q        <= ENQ_BACK;
      data_q      <= '0;
      resp_op_q   <= ENQ_BACK;
      resp_data_q <= '0;
      resp_lat_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (io.cmd_val) begin
            op_q    <= io.cmd_op;
            data_q  <= io.cmd_data;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (lat_now >= TIMEOUT_LAT) begin
            timeout_q <= 1'b1;
          end
          if (sel_cpl) begin
            resp_op_q   <= op_q;
            resp_data_q <= is_deq(op_q) ? sel_deq_data : '0;
            resp_lat_q  <= lat_now;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (io.resp_rdy) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Reqs decode from state only so an async reset drops them at once.
  assign io.enq_back_req   = (state_q == ST_ISSUE) && (op_q == ENQ_BACK);
  assign io.enq_front_req  = (state_q == ST_ISSUE) && (op_q == ENQ_FRONT);
  assign io.deq_front_req  = (state_q == ST_ISSUE) && (op_q == DEQ_FRONT);
  assign io.deq_back_req   = (state_q == ST_ISSUE) && (op_q == DEQ_BACK);
  assign io.enq_back_data  = data_q;
  assign io.enq_front_data = data_q;

  assign io.cmd_rdy   = (state_q == ST_IDLE);
  assign io.resp_val  = (state_q == ST_RESP);
  assign io.resp_op   = resp_op_q;
  assign io.resp_data = resp_data_q;
  assign io.resp_lat  = resp_lat_q;
  assign io.timeout   = timeout_q;

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_deque_op_issuer.sv
// Directed bench for deque_op_issuer: reset behaviour, latency, back-to-back
// throughput, response stall and timeout, with hand-computed expectations.
module tb_deque_op_issuer;
  import deque_pkg::*;

  localparam int W = 8;
  localparam int L = 8;

  logic   clk;
  logic   rst;
  state_t dbg_state;
  int     checks   = 0;
  int     failures = 0;
  int     cyc      = 0;
  int     last_resp_cyc;
  logic [W-1:0] exp_q[$];

  deque_op_issuer_if #(.p_bitwidth(W), .p_latwidth(L)) bus ();

  deque_op_issuer #(.p_bitwidth(W), .p_latwidth(L), .p_timeout(200)) dut (
    .clk         (clk),
    .rst         (rst),
    .io          (bus.master),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] reqs();
    return {bus.deq_back_req, bus.deq_front_req, bus.enq_front_req, bus.enq_back_req};
  endfunction

  // driver tasks
  task automatic send_cmd(input op_t op, input logic [W-1:0] data);
    bus.cmd_val  = 1'b1;
    bus.cmd_op   = op;
    bus.cmd_data = data;
    step();
    bus.cmd_val  = 1'b0;
  endtask

  task automatic set_cpl(input op_t op, input logic v);
    case (op)
      ENQ_BACK:  bus.enq_back_cpl  = v;
      ENQ_FRONT: bus.enq_front_cpl = v;
      DEQ_FRONT: bus.deq_front_cpl = v;
      default:   bus.deq_back_cpl  = v;
    endcase
  endtask

  task automatic set_all_cpl(input logic v);
    bus.enq_back_cpl  = v;
    bus.enq_front_cpl = v;
    bus.deq_front_cpl = v;
    bus.deq_back_cpl  = v;
  endtask

  task automatic accept_resp();
    bus.resp_rdy = 1'b1;
    step();
    bus.resp_rdy = 1'b0;
  endtask

  initial begin
    logic [W-1:0] exp_data;
    bus.cmd_val        = 1'b0;
    bus.cmd_op         = ENQ_BACK;
    bus.cmd_data       = '0;
    bus.resp_rdy       = 1'b0;
    bus.deq_front_data = '0;
    bus.deq_back_data  = '0;
    set_all_cpl(1'b0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    step();

    // reset state
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_cmd_rdy", bus.cmd_rdy, 1);
    chk("rst_resp_val", bus.resp_val, 0);
    chk("rst_resp_op", bus.resp_op, 0);
    chk("rst_resp_data", bus.resp_data, 0);
    chk("rst_resp_lat", bus.resp_lat, 0);
    chk("rst_timeout", bus.timeout, 0);
    chk("rst_reqs", reqs(), 0);
    chk("rst_enq_back_data", bus.enq_back_data, 0);
    chk("rst_enq_front_data", bus.enq_front_data, 0);

    // reset mid-ISSUE on DEQ_BACK
    send_cmd(DEQ_BACK, 8'h77);
    chk("midrst_req_before", reqs(), 4'b1000);
    step();
    step();
    #2 rst = 1'b0;
    #1;
    chk("midrst_req_async_drop", reqs(), 0);
    chk("midrst_state", dbg_state, ST_IDLE);
    step();
    #1 rst = 1'b1;
    step();
    chk("midrst_resp_val", bus.resp_val, 0);
    chk("midrst_cmd_rdy", bus.cmd_rdy, 1);
    chk("midrst_timeout", bus.timeout, 0);

    // ENQ_BACK 0xA5, cpl in the same cycle as req
    send_cmd(ENQ_BACK, 8'hA5);
    chk("eb_req", reqs(), 4'b0001);
    chk("eb_enq_back_data", bus.enq_back_data, 8'hA5);
    chk("eb_enq_front_data", bus.enq_front_data, 8'hA5);
    chk("eb_cmd_rdy_issue", bus.cmd_rdy, 0);
    set_cpl(ENQ_BACK, 1'b1);
    step();
    set_cpl(ENQ_BACK, 1'b0);
    chk("eb_req_dropped", reqs(), 0);
    chk("eb_resp_val", bus.resp_val, 1);
    chk("eb_resp_op", bus.resp_op, 0);
    chk("eb_resp_data", bus.resp_data, 0);
    chk("eb_resp_lat", bus.resp_lat, 1);
    accept_resp();
    chk("eb_back_idle", bus.cmd_rdy, 1);
    chk("eb_resp_val_low", bus.resp_val, 0);

    // DEQ_FRONT, cpl 4 cycles after req; a foreign cpl is noise
    send_cmd(DEQ_FRONT, 8'h00);
    bus.deq_back_cpl = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("df_req_wait", reqs(), 4'b0100);
      step();
    end
    bus.deq_back_cpl   = 1'b0;
    bus.deq_front_cpl  = 1'b1;
    bus.deq_front_data = 8'h3C;
    step();
    bus.deq_front_cpl  = 1'b0;
    bus.deq_front_data = 8'hFF;
    chk("df_reqs_off", reqs(), 0);
    chk("df_resp_val", bus.resp_val, 1);
    chk("df_resp_op", bus.resp_op, 2);
    chk("df_resp_data", bus.resp_data, 8'h3C);
    chk("df_resp_lat", bus.resp_lat, 4);

    // stall in RESP: resp held, commands and cpls ignored
    bus.cmd_val  = 1'b1;
    bus.cmd_op   = ENQ_FRONT;
    bus.cmd_data = 8'h99;
    set_all_cpl(1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_resp_val", bus.resp_val, 1);
      chk("stall_resp_op", bus.resp_op, 2);
      chk("stall_resp_data", bus.resp_data, 8'h3C);
      chk("stall_resp_lat", bus.resp_lat, 4);
      chk("stall_cmd_rdy", bus.cmd_rdy, 0);
      chk("stall_reqs", reqs(), 0);
    end
    bus.cmd_val = 1'b0;
    set_all_cpl(1'b0);
    accept_resp();
    chk("stall_released", dbg_state, ST_IDLE);

    // back-to-back, all opcodes, cpl immediate, resp_rdy held high
    bus.deq_front_data = 8'hC3;
    bus.deq_back_data  = 8'h96;
    bus.resp_rdy       = 1'b1;
    last_resp_cyc      = 0;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: exp_q.push_back(8'h00);
        1: exp_q.push_back(8'h00);
        2: exp_q.push_back(8'hC3);
        default: exp_q.push_back(8'h96);
      endcase
      send_cmd(op_t'(i[1:0]), W'(8'h10 + i));
      chk("b2b_req", reqs(), 32'd1 << i);
      chk("b2b_enq_data", bus.enq_back_data, 8'h10 + i);
      set_cpl(op_t'(i[1:0]), 1'b1);
      step();
      set_cpl(op_t'(i[1:0]), 1'b0);
      exp_data = exp_q.pop_front();
      chk("b2b_resp_val", bus.resp_val, 1);
      chk("b2b_resp_op", bus.resp_op, i);
      chk("b2b_resp_data", bus.resp_data, exp_data);
      chk("b2b_resp_lat", bus.resp_lat, 1);
      chk("b2b_reqs_off", reqs(), 0);
      if (i > 0) chk("b2b_spacing", cyc - last_resp_cyc, 3);
      last_resp_cyc = cyc;
      step();
      chk("b2b_idle", bus.cmd_rdy, 1);
    end
    bus.resp_rdy = 1'b0;
    chk("b2b_queue_empty", exp_q.size(), 0);

    // DEQ_BACK with cpl withheld for 210 cycles
    send_cmd(DEQ_BACK, 8'h00);
    repeat (199) step();
    chk("to_before", bus.timeout, 0);
    step();
    chk("to_set", bus.timeout, 1);
    chk("to_req_held", reqs(), 4'b1000);
    repeat (9) step();
    bus.deq_back_cpl  = 1'b1;
    bus.deq_back_data = 8'h5A;
    step();
    bus.deq_back_cpl  = 1'b0;
    chk("to_resp_val", bus.resp_val, 1);
    chk("to_resp_op", bus.resp_op, 3);
    chk("to_resp_data", bus.resp_data, 8'h5A);
    chk("to_resp_lat", bus.resp_lat, 210);
    accept_resp();
    chk("to_sticky_idle", bus.timeout, 1);

    // further op: timeout stays set
    send_cmd(ENQ_FRONT, 8'h5E);
    chk("ef_req", reqs(), 4'b0010);
    chk("ef_enq_front_data", bus.enq_front_data, 8'h5E);
    step();
    bus.enq_front_cpl = 1'b1;
    step();
    bus.enq_front_cpl = 1'b0;
    chk("ef_resp_op", bus.resp_op, 1);
    chk("ef_resp_data", bus.resp_data, 0);
    chk("ef_resp_lat", bus.resp_lat, 2);
    chk("ef_timeout_sticky", bus.timeout, 1);
    accept_resp();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
